// File: rtl/wta_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wta_sequencer_pkg
// Description : Shared definitions for the winner-take-all sequencer: default
//               cost width, FSM state type and a constant clog2 helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wta_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,  // collecting chunks of a pixel
    FLUSH = 1'b1   // next accepted chunk is the last one of the pixel
  } state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/argmin_8.sv
`default_nettype none
// ============================================================================
// Module      : argmin_8
// Description : Combinational minimum of eight packed costs. Ties resolve to
//               the lowest lane index.
// Ports       : costs    - 8 packed costs, lane k at [WIDTH*k +: WIDTH]
//               min_cost - smallest cost
//               min_lane - lane index (0..7) of the smallest cost
// Revision    : 1.0 - initial release
// ============================================================================
module argmin_8
  import wta_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [8*WIDTH-1:0] costs,
  output logic [WIDTH-1:0]   min_cost,
  output logic [2:0]         min_lane
);

  always_comb begin
    min_cost = costs[WIDTH-1:0];
    min_lane = 3'd0;
    // Strict compare: a later lane must be strictly cheaper to win.
    for (int k = 1; k < 8; k++) begin
      if (costs[WIDTH*k +: WIDTH] < min_cost) begin
        min_cost = costs[WIDTH*k +: WIDTH];
        min_lane = 3'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wta_sequencer
// Description : Winner-take-all disparity selector. Accepts CHUNKS beats of
//               eight aggregated costs per pixel and returns the disparity
//               with the minimum cost (lowest disparity on ties).
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_valid/in_ready  - input chunk handshake
//               in_costs           - 8 packed costs, lane k = disparity chunk*8+k
//               out_valid/out_ready- result handshake
//               out_disp/out_cost  - winning disparity and its cost
// Revision    : 1.0 - initial release
// ============================================================================
module wta_sequencer
  import wta_sequencer_pkg::*;
#(
  parameter  int WIDTH     = DEFAULT_WIDTH,
  parameter  int CHUNKS    = 8,
  localparam int DISP_BITS = clog2(CHUNKS) + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WIDTH-1:0]   in_costs,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DISP_BITS-1:0] out_disp,
  output logic [WIDTH-1:0]     out_cost
);

  localparam int                CNT_BITS = (CHUNKS > 1) ? clog2(CHUNKS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(CHUNKS - 1);

  if (CHUNKS < 1 || CHUNKS > 64 || (CHUNKS & (CHUNKS - 1)) != 0) begin : g_chunks_check
    $error("wta_sequencer: CHUNKS must be a power of two in 1..64");
  end
  if (WIDTH < 1) begin : g_width_check
    $error("wta_sequencer: WIDTH must be positive");
  end

  state_t              state, state_next;
  logic [CNT_BITS-1:0] chunk_cnt, chunk_cnt_next;
  logic [WIDTH-1:0]    run_cost;
  logic [DISP_BITS-1:0] run_disp;

  logic [WIDTH-1:0]     chunk_cost;
  logic [2:0]           chunk_lane;
  logic [DISP_BITS-1:0] chunk_disp;
  logic                 is_first, is_last, in_xfer, take_chunk;
  logic [WIDTH-1:0]     sel_cost;
  logic [DISP_BITS-1:0] sel_disp;

  argmin_8 #(.WIDTH(WIDTH)) u_argmin (
    .costs    (in_costs),
    .min_cost (chunk_cost),
    .min_lane (chunk_lane)
  );

  // With a single chunk every beat both opens and closes a pixel.
  assign is_last  = (CHUNKS == 1) ? 1'b1 : (state == FLUSH);
  assign is_first = (chunk_cnt == '0);

  // The last chunk must wait while an unconsumed result still occupies
  // the output registers; earlier chunks never touch them.
  assign in_ready = !rst && !(is_last && out_valid && !out_ready);
  assign in_xfer  = in_valid && in_ready;

  // chunk_cnt*8 + lane is a plain concatenation because 8 is a power of two.
  assign chunk_disp = DISP_BITS'({chunk_cnt, chunk_lane});
  assign take_chunk = is_first || (chunk_cost < run_cost);
  assign sel_cost   = take_chunk ? chunk_cost : run_cost;
  assign sel_disp   = take_chunk ? chunk_disp : run_disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      chunk_cnt <= '0;
    end else begin
      state     <= state_next;
      chunk_cnt <= chunk_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    chunk_cnt_next = chunk_cnt;
    if (in_xfer) begin
      if (is_last) begin
        chunk_cnt_next = '0;
        state_next     = ACCUM;
      end else begin
        chunk_cnt_next = chunk_cnt + CNT_BITS'(1);
        state_next     = (chunk_cnt_next == LAST_CNT) ? FLUSH : ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cost  <= '0;
      run_disp  <= '0;
      out_cost  <= '0;
      out_disp  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_xfer && !is_last) begin
        run_cost <= sel_cost;
        run_disp <= sel_disp;
      end
      // A new result replacing one being consumed keeps out_valid high.
      if (in_xfer && is_last) begin
        out_cost  <= sel_cost;
        out_disp  <= sel_disp;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wta_sequencer
// Description : Self-checking bench for wta_sequencer (WIDTH=8, CHUNKS=4)
//               against a whole-pixel minimum search reference.
// Ports       : none (testbench)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wta_sequencer;

  localparam int WIDTH  = 8;
  localparam int CHUNKS = 4;
  localparam int D      = 8 * CHUNKS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_costs = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [4:0]       out_disp;
  logic [7:0]       out_cost;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  px [D];
  logic [12:0] got_q [$];
  int          got_cyc [$];
  logic [12:0] exp_q [$];
  int cyc = 0, in_xfers = 0, stalls = 0, hold_viol = 0;
  logic prev_hold = 1'b0;
  logic [4:0] prev_disp;
  logic [7:0] prev_cost;
  logic rnd_ready = 1'b0;

  wta_sequencer #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_costs  (in_costs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_disp  (out_disp),
    .out_cost  (out_cost)
  );

  always #5 clk = ~clk;

  // Observe handshakes mid-cycle; the values seen here are what the next
  // rising edge acts on.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!out_valid || out_disp !== prev_disp || out_cost !== prev_cost))
        hold_viol++;
      prev_hold = out_valid && !out_ready;
      prev_disp = out_disp;
      prev_cost = out_cost;
      if (out_valid && out_ready) begin
        got_q.push_back({out_disp, out_cost});
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready)  in_xfers++;
      if (in_valid && !in_ready) stalls++;
    end
  end

  // Reference: scan all disparities, strictly-smaller wins, so ties keep
  // the lowest disparity.
  function automatic logic [12:0] ref_min();
    int best;
    best = 0;
    for (int d = 1; d < D; d++) if (px[d] < px[best]) best = d;
    return {5'(best), px[best]};
  endfunction

  function automatic logic [63:0] pack(input int c);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = px[c*8 + k];
    return v;
  endfunction

  task automatic fill(input int lo, input int hi);
    for (int d = 0; d < D; d++) px[d] = 8'($urandom_range(hi, lo));
  endtask

  task automatic drive_chunk(input int c);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_costs = pack(c);
    if (rnd_ready) out_ready = ($urandom_range(2, 0) != 0);
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_pixel();
    exp_q.push_back(ref_min());
    for (int c = 0; c < CHUNKS; c++) drive_chunk(c);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_costs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_disp !== 5'd0 || out_cost !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_state: out_valid=%0b in_ready=%0b disp=%0d cost=%0d, required 0 0 0 0",
               out_valid, in_ready, out_disp, out_cost);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_min();
    clear_q();
    out_ready = 1'b1;
    fill(10, 255);
    px[19] = 8'd5;
    exp_q.push_back(ref_min());
    for (int c = 0; c < CHUNKS - 1; c++) drive_chunk(c);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early_valid: out_valid=%0b before last chunk, required 0", out_valid);
    end
    drive_chunk(CHUNKS - 1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_disp !== 5'd19 || out_cost !== 8'd5) begin
      n_bad++;
      $display("FAIL single_min: valid=%0b disp=%0d cost=%0d, required 1 19 5",
               out_valid, out_disp, out_cost);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || got_q.size() != 1) begin
      n_bad++;
      $display("FAIL single_consume: valid=%0b results=%0d, required 0 1", out_valid, got_q.size());
    end
  endtask

  task automatic test_ties();
    clear_q();
    fill(4, 255);
    px[2] = 8'd3; px[9] = 8'd3; px[30] = 8'd3;
    drive_pixel();
    n_cmp++;
    if (out_valid !== 1'b1 || out_disp !== 5'd2 || out_cost !== 8'd3) begin
      n_bad++;
      $display("FAIL ties: valid=%0b disp=%0d cost=%0d, required 1 2 3", out_valid, out_disp, out_cost);
    end
    drain();
  endtask

  task automatic test_all_max();
    clear_q();
    for (int d = 0; d < D; d++) px[d] = 8'd255;
    drive_pixel();
    n_cmp++;
    if (out_valid !== 1'b1 || out_disp !== 5'd0 || out_cost !== 8'd255) begin
      n_bad++;
      $display("FAIL all_max: valid=%0b disp=%0d cost=%0d, required 1 0 255", out_valid, out_disp, out_cost);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_a, exp_b;
    clear_q();
    out_ready = 1'b0;
    fill(0, 255);
    exp_a = ref_min();
    for (int c = 0; c < CHUNKS; c++) drive_chunk(c);
    fill(0, 255);
    exp_b = ref_min();
    for (int c = 0; c < CHUNKS - 1; c++) drive_chunk(c);
    in_valid = 1'b1;
    in_costs = pack(CHUNKS - 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_disp, out_cost} !== exp_a) begin
        n_bad++;
        $display("FAIL b2b_stall: ready=%0b valid=%0b disp=%0d cost=%0d, required 0 1 %0d %0d",
                 in_ready, out_valid, out_disp, out_cost, exp_a[12:8], exp_a[7:0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_release: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || {out_disp, out_cost} !== exp_b) begin
      n_bad++;
      $display("FAIL b2b_second: valid=%0b disp=%0d cost=%0d, required 1 %0d %0d",
               out_valid, out_disp, out_cost, exp_b[12:8], exp_b[7:0]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (got_q.size() != 2 || got_q[0] !== exp_a || got_q[1] !== exp_b) begin
      n_bad++;
      $display("FAIL b2b_results: count=%0d first=%h second=%h, required 2 %h %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 13'h0,
               (got_q.size() > 1) ? got_q[1] : 13'h0, exp_a, exp_b);
    end
  endtask

  task automatic test_stream();
    int x0, s0;
    clear_q();
    out_ready = 1'b1;
    x0 = in_xfers;
    s0 = stalls;
    for (int p = 0; p < 4; p++) begin
      fill(0, 255);
      drive_pixel();
    end
    drain();
    n_cmp++;
    if (in_xfers - x0 != 16 || stalls - s0 != 0) begin
      n_bad++;
      $display("FAIL stream_rate: transfers=%0d stalls=%0d, required 16 0", in_xfers - x0, stalls - s0);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stream_result[%0d]: got=%h, required %h", i,
                 (i < got_q.size()) ? got_q[i] : 13'h1fff, exp_q[i]);
      end
    end
    n_cmp++;
    if (got_cyc.size() != 4 || got_cyc[1] - got_cyc[0] != 4 ||
        got_cyc[2] - got_cyc[1] != 4 || got_cyc[3] - got_cyc[2] != 4) begin
      n_bad++;
      $display("FAIL stream_spacing: results=%0d, required 4 results 4 cycles apart", got_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    out_ready = 1'b1;
    fill(0, 255);
    px[0] = 8'd0;
    drive_chunk(0);
    drive_chunk(1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fill(1, 255);
    px[31] = 8'd0;
    drive_pixel();
    drain();
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== {5'd31, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_mid: count=%0d first=%h, required 1 %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 13'h0, {5'd31, 8'd0});
    end
  endtask

  task automatic test_random();
    int h0, n;
    clear_q();
    h0 = hold_viol;
    rnd_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      fill(0, 15);
      exp_q.push_back(ref_min());
      for (int c = 0; c < CHUNKS; c++) begin
        drive_chunk(c);
        repeat ($urandom_range(2, 0)) @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    drain();
    n = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n++;
        $display("FAIL random_result[%0d]: got=%h, required %h", i,
                 (i < got_q.size()) ? got_q[i] : 13'h1fff, exp_q[i]);
      end
    end
    n_cmp++;
    if (n != 0 || got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL random_summary: %0d wrong, count=%0d, required 0 wrong and %0d", n, got_q.size(), exp_q.size());
    end
    n_cmp++;
    if (hold_viol - h0 != 0) begin
      n_bad++;
      $display("FAIL hold_stable: %0d changes while held, required 0", hold_viol - h0);
    end
  endtask

  initial begin
    test_reset();
    test_single_min();
    test_ties();
    test_all_max();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
